// File: rtl/fet_iv_sweeper_if.sv
// Piecewise-linear signal type and the sweeper's configuration, stimulus and result bundle.
// The master side configures sweeps and models the device; the slave side is the sweeper.
`timescale 1ns/1ps
package fet_iv_pkg;
    // value a, slope b, and time t at which a is valid
    typedef struct {
        real a;
        real b;
        real t;
    } pwl;
endpackage

interface fet_iv_sweeper_if #(parameter int CW = 8);
    import fet_iv_pkg::*;

    logic          start;
    real           vg_start;
    real           vg_step;
    real           vd_start;
    real           vd_step;
    logic [CW-1:0] n_vg;
    logic [CW-1:0] n_vd;
    logic [CW-1:0] settle_cycles;
    pwl            id;
    pwl            vg;
    pwl            vd;
    logic          res_valid;
    logic          res_ready;
    real           res_vg;
    real           res_vd;
    real           res_id;
    logic          busy;
    logic          done;

    modport master (
        output start, vg_start, vg_step, vd_start, vd_step,
        output n_vg, n_vd, settle_cycles, id, res_ready,
        input  vg, vd, res_valid, res_vg, res_vd, res_id, busy, done
    );

    modport slave (
        input  start, vg_start, vg_step, vd_start, vd_step,
        input  n_vg, n_vd, settle_cycles, id, res_ready,
        output vg, vd, res_valid, res_vg, res_vd, res_id, busy, done
    );
endinterface

// File: rtl/fet_iv_sweeper.sv
// Two-dimensional FET I-V sweep sequencer: steps gate (outer) and drain (inner) bias,
// waits a settle time, samples drain current and hands each point out over valid/ready.
`timescale 1ns/1ps
module fet_iv_sweeper #(
    parameter int CW         = 8,
    parameter int SETTLE_DEF = 4
) (
    input logic            clk,
    input logic            rst,
    fet_iv_sweeper_if.slave sw
);
    import fet_iv_pkg::*;

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, OUT, DONE} state_t;

    state_t        state;
    real           cfg_vg_start;
    real           cfg_vg_step;
    real           cfg_vd_start;
    real           cfg_vd_step;
    logic [CW-1:0] cfg_n_vg;
    logic [CW-1:0] cfg_n_vd;
    logic [CW-1:0] cfg_settle;
    logic [CW-1:0] ig;
    logic [CW-1:0] idx;
    logic [CW-1:0] cnt;
    pwl            vg_q;
    pwl            vd_q;
    real           res_vg_q;
    real           res_vd_q;
    real           res_id_q;
    logic          res_valid_q;
    logic          busy_q;
    logic          done_q;

    assign sw.vg        = vg_q;
    assign sw.vd        = vd_q;
    assign sw.res_vg    = res_vg_q;
    assign sw.res_vd    = res_vd_q;
    assign sw.res_id    = res_id_q;
    assign sw.res_valid = res_valid_q;
    assign sw.busy      = busy_q;
    assign sw.done      = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cfg_vg_start <= 0.0;
            cfg_vg_step  <= 0.0;
            cfg_vd_start <= 0.0;
            cfg_vd_step  <= 0.0;
            cfg_n_vg     <= '0;
            cfg_n_vd     <= '0;
            cfg_settle   <= '0;
            ig           <= '0;
            idx          <= '0;
            cnt          <= '0;
            vg_q.a       <= 0.0;
            vg_q.b       <= 0.0;
            vg_q.t       <= $realtime;
            vd_q.a       <= 0.0;
            vd_q.b       <= 0.0;
            vd_q.t       <= $realtime;
            res_vg_q     <= 0.0;
            res_vd_q     <= 0.0;
            res_id_q     <= 0.0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (sw.start) begin
                        cfg_vg_start <= sw.vg_start;
                        cfg_vg_step  <= sw.vg_step;
                        cfg_vd_start <= sw.vd_start;
                        cfg_vd_step  <= sw.vd_step;
                        cfg_n_vg     <= sw.n_vg;
                        cfg_n_vd     <= sw.n_vd;
                        cfg_settle   <= (sw.settle_cycles == '0) ? CW'(SETTLE_DEF) : sw.settle_cycles;
                        ig           <= '0;
                        idx          <= '0;
                        busy_q       <= 1'b1;
                        // an empty grid produces no points, only the completion pulse
                        if (sw.n_vg == '0 || sw.n_vd == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= DRIVE;
                        end
                    end
                end
                DRIVE: begin
                    vg_q.a <= cfg_vg_start + real'(ig) * cfg_vg_step;
                    vg_q.b <= 0.0;
                    vg_q.t <= $realtime;
                    vd_q.a <= cfg_vd_start + real'(idx) * cfg_vd_step;
                    vd_q.b <= 0.0;
                    vd_q.t <= $realtime;
                    cnt    <= '0;
                    state  <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == cfg_settle - CW'(1)) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SAMPLE: begin
                    // extrapolate the device current to the sampling instant
                    res_id_q    <= sw.id.a + sw.id.b * ($realtime - sw.id.t);
                    res_vg_q    <= vg_q.a;
                    res_vd_q    <= vd_q.a;
                    res_valid_q <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (sw.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (idx == cfg_n_vd - CW'(1)) begin
                            idx <= '0;
                            ig  <= ig + CW'(1);
                            if (ig == cfg_n_vg - CW'(1)) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                state <= DRIVE;
                            end
                        end else begin
                            idx   <= idx + CW'(1);
                            state <= DRIVE;
                        end
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fet_iv_sweeper.sv
// Randomised scoreboard bench for fet_iv_sweeper driving a simple nfet current model.
`timescale 1ns/1ps
module tb_fet_iv_sweeper;
    import fet_iv_pkg::*;

    localparam int  CW  = 8;
    localparam real TCK = 10.0;
    localparam real VTH = 0.4;
    localparam real GM  = 1e-3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fet_iv_sweeper_if #(.CW(CW)) bus ();

    fet_iv_sweeper #(.CW(CW), .SETTLE_DEF(4)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (bus)
    );

    always #5 clk = ~clk;

    int  n_checks   = 0;
    int  n_fail     = 0;
    int  cyc        = 0;
    int  hs_cnt     = 0;
    int  done_cnt   = 0;
    int  ready_mode = 0;
    int  rise_q[$];
    real q_vg[$];
    real q_vd[$];
    real q_id[$];
    real id_slope   = 0.0;

    always @(posedge clk) cyc <= cyc + 1;

    // device under characterisation: linear-then-saturating nfet, optional current ramp
    function automatic real nfet(real vgv, real vdv);
        real vov;
        real vdp;
        vov = vgv - VTH;
        vdp = (vdv > 0.0) ? vdv : 0.0;
        if (vov <= 0.0) return 0.0;
        return GM * ((vdp < vov) ? vdp : vov);
    endfunction

    always_comb begin
        bus.id.a = nfet(bus.vg.a, bus.vd.a);
        bus.id.b = id_slope;
        bus.id.t = bus.vg.t;
    end

    task automatic chk_real(string name, real act, real exp);
        real tol;
        tol = 1e-12 + 1e-9 * ((exp < 0.0) ? -exp : exp);
        n_checks++;
        if ((act - exp) > tol || (exp - act) > tol) begin
            n_fail++;
            $display("FAIL %s: got %g required %g", name, act, exp);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push_model(int nvg, int nvd, int s_eff, real vgs, real vgst,
                              real vds, real vdst, real slope);
        real a;
        real b;
        for (int g = 0; g < nvg; g++) begin
            for (int d = 0; d < nvd; d++) begin
                a = vgs + g * vgst;
                b = vds + d * vdst;
                q_vg.push_back(a);
                q_vd.push_back(b);
                q_id.push_back(nfet(a, b) + slope * (s_eff + 1) * TCK);
            end
        end
    endtask

    task automatic start_sweep(int nvg, int nvd, int st, real vgs, real vgst, real vds, real vdst);
        @(posedge clk); #1;
        bus.vg_start      = vgs;
        bus.vg_step       = vgst;
        bus.vd_start      = vds;
        bus.vd_step       = vdst;
        bus.n_vg          = CW'(nvg);
        bus.n_vd          = CW'(nvd);
        bus.settle_cycles = CW'(st);
        bus.start         = 1'b1;
        @(posedge clk); #1;
        bus.start         = 1'b0;
        bus.vg_start      = vgs + 1.25;
        bus.vg_step       = vgst * 2.0 + 0.3;
        bus.vd_start      = vds - 0.7;
        bus.vd_step       = vdst + 0.45;
        bus.n_vg          = CW'(nvg + 1);
        bus.n_vd          = CW'(nvd + 2);
        bus.settle_cycles = CW'(st + 3);
    endtask

    task automatic wait_done(int d0, int limit);
        int i;
        i = 0;
        while (done_cnt == d0 && i < limit) begin
            @(posedge clk);
            i++;
        end
        if (done_cnt == d0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done within %0d cycles, required a done pulse", limit);
        end
    endtask

    task automatic run_sweep(string tag, bit use_model, int nvg, int nvd, int st,
                             real vgs, real vgst, real vds, real vdst, int mode, real slope);
        int s_eff;
        int d0;
        int h0;
        int r0;
        s_eff      = (st == 0) ? 4 : st;
        ready_mode = mode;
        id_slope   = slope;
        if (use_model) push_model(nvg, nvd, s_eff, vgs, vgst, vds, vdst, slope);
        d0 = done_cnt;
        h0 = hs_cnt;
        r0 = rise_q.size();
        start_sweep(nvg, nvd, st, vgs, vgst, vds, vdst);
        // a second start while busy must be ignored
        @(posedge clk); #1; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        wait_done(d0, 4000);
        repeat (3) @(posedge clk);
        chk_int({tag, "_results"}, hs_cnt - h0, nvg * nvd);
        chk_int({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk_int({tag, "_queue_left"}, q_vg.size(), 0);
        if (mode == 0) begin
            for (int k = r0 + 1; k < rise_q.size(); k++)
                chk_int({tag, "_valid_gap"}, rise_q[k] - rise_q[k-1], s_eff + 3);
        end
        q_vg.delete();
        q_vd.delete();
        q_id.delete();
    endtask

    initial begin : ready_drv
        bus.res_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.res_ready = 1'b1;
                1:       bus.res_ready = ($urandom_range(0, 3) != 0);
                default: bus.res_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        logic prev_valid;
        real  e_vg;
        real  e_vd;
        real  e_id;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (bus.res_valid && !prev_valid) rise_q.push_back(cyc);
                prev_valid = bus.res_valid;
                if (bus.done) done_cnt++;
                if (bus.res_valid && bus.res_ready) begin
                    hs_cnt++;
                    if (q_vg.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got vg=%g vd=%g id=%g, required no result",
                                 bus.res_vg, bus.res_vd, bus.res_id);
                    end else begin
                        e_vg = q_vg.pop_front();
                        e_vd = q_vd.pop_front();
                        e_id = q_id.pop_front();
                        chk_real("res_vg", bus.res_vg, e_vg);
                        chk_real("res_vd", bus.res_vd, e_vd);
                        chk_real("res_id", bus.res_id, e_id);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int  d0;
        int  h0;
        int  r0;
        int  i;
        int  stable;
        real c_vg, c_vd, c_id, c_ga, c_gt, c_da;
        real t_rst;

        bus.start         = 1'b0;
        bus.vg_start      = 0.0;
        bus.vg_step       = 0.0;
        bus.vd_start      = 0.0;
        bus.vd_step       = 0.0;
        bus.n_vg          = '0;
        bus.n_vd          = '0;
        bus.settle_cycles = '0;

        // reset state
        repeat (3) @(posedge clk);
        #2;
        chk_int("rst_busy", int'(bus.busy), 0);
        chk_int("rst_done", int'(bus.done), 0);
        chk_int("rst_valid", int'(bus.res_valid), 0);
        chk_real("rst_res_vg", bus.res_vg, 0.0);
        chk_real("rst_res_id", bus.res_id, 0.0);
        chk_real("rst_vg_a", bus.vg.a, 0.0);
        chk_real("rst_vd_b", bus.vd.b, 0.0);
        rst = 1'b0;

        // reference sweep with literal expected points, default settle
        q_vg = '{0.0, 0.0, 0.5, 0.5, 1.0, 1.0};
        q_vd = '{0.0, 1.0, 0.0, 1.0, 0.0, 1.0};
        q_id = '{0.0, 0.0, 0.0, 1e-4, 0.0, 6e-4};
        run_sweep("ref_s0", 1'b0, 3, 2, 0, 0.0, 0.5, 0.0, 1.0, 0, 0.0);
        run_sweep("ref_s2", 1'b1, 3, 2, 2, 0.0, 0.5, 0.0, 1.0, 0, 0.0);

        // backpressure at the first result
        ready_mode = 2;
        id_slope   = 2e-7;
        push_model(2, 2, 1, 0.6, 0.2, 0.1, 0.3, 2e-7);
        d0 = done_cnt;
        h0 = hs_cnt;
        start_sweep(2, 2, 1, 0.6, 0.2, 0.1, 0.3);
        i = 0;
        while (!bus.res_valid && i < 50) begin
            @(posedge clk); #2;
            i++;
        end
        chk_int("stall_first_valid", int'(bus.res_valid), 1);
        c_vg = bus.res_vg; c_vd = bus.res_vd; c_id = bus.res_id;
        c_ga = bus.vg.a;   c_gt = bus.vg.t;   c_da = bus.vd.a;
        stable = 1;
        repeat (10) begin
            @(posedge clk); #2;
            if (!bus.res_valid || bus.res_vg != c_vg || bus.res_vd != c_vd || bus.res_id != c_id ||
                bus.vg.a != c_ga || bus.vg.t != c_gt || bus.vd.a != c_da) stable = 0;
        end
        chk_int("stall_stable", stable, 1);
        chk_int("stall_no_handshake", hs_cnt - h0, 0);
        ready_mode = 0;
        wait_done(d0, 500);
        repeat (3) @(posedge clk);
        chk_int("stall_results", hs_cnt - h0, 4);
        chk_int("stall_queue_left", q_vg.size(), 0);

        // empty drain axis
        d0 = done_cnt;
        r0 = rise_q.size();
        start_sweep(3, 0, 0, 0.0, 0.5, 0.0, 1.0);
        @(negedge clk);
        chk_int("empty_busy_1st", int'(bus.busy), 1);
        chk_int("empty_done_1st", int'(bus.done), 1);
        @(negedge clk);
        chk_int("empty_busy_2nd", int'(bus.busy), 0);
        chk_int("empty_done_2nd", int'(bus.done), 0);
        repeat (4) @(posedge clk);
        chk_int("empty_no_valid", rise_q.size() - r0, 0);
        chk_int("empty_done_pulses", done_cnt - d0, 1);

        // reset during settle of the third point, then restart
        ready_mode = 0;
        id_slope   = 0.0;
        push_model(3, 2, 4, 0.0, 0.5, 0.0, 1.0, 0.0);
        h0 = hs_cnt;
        start_sweep(3, 2, 0, 0.0, 0.5, 0.0, 1.0);
        i = 0;
        while (hs_cnt < h0 + 2 && i < 100) begin
            @(posedge clk);
            i++;
        end
        chk_int("midrst_two_points", hs_cnt - h0, 2);
        @(posedge clk);
        #3;
        rst   = 1'b1;
        t_rst = $realtime;
        #1;
        chk_int("midrst_busy", int'(bus.busy), 0);
        chk_int("midrst_valid", int'(bus.res_valid), 0);
        chk_int("midrst_done", int'(bus.done), 0);
        chk_real("midrst_vg_a", bus.vg.a, 0.0);
        chk_real("midrst_vd_a", bus.vd.a, 0.0);
        chk_real("midrst_vg_t", bus.vg.t, t_rst);
        chk_real("midrst_res_vg", bus.res_vg, 0.0);
        q_vg.delete();
        q_vd.delete();
        q_id.delete();
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        chk_int("midrst_no_more", hs_cnt - h0, 2);
        run_sweep("restart", 1'b1, 3, 2, 0, 0.0, 0.5, 0.0, 1.0, 0, 0.0);

        // randomised sweeps
        for (int k = 0; k < 8; k++) begin
            run_sweep("rand", 1'b1,
                      int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(0, 5)),
                      real'($urandom_range(0, 10)) * 0.1, real'($urandom_range(0, 5)) * 0.1,
                      real'($urandom_range(0, 10)) * 0.1, real'($urandom_range(0, 5)) * 0.1,
                      int'($urandom_range(0, 1)), real'($urandom_range(0, 100)) * 1e-8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
